cond_unit: RTL

//  Consumer side of the ALU flag interface: latches ALUFlag {N,Z,C,V} into an architectural

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/cond_unit_if.sv | 32 +++
 rtl/cond_unit_check.sv | 40 ++++
 rtl/cond_unit.sv | 59 +++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU condition codes and flag bit positions
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'ha, LT = 4'hb,
    GT = 4'hc, LE = 4'hd, AL = 4'he, NV = 4'hf
  } cond_e;

  // Positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Positions inside the decoder's FlagW field
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - decoder/alu to condition unit signal bundle
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlag;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SkipCount;

  // Decoder/datapath side: drives the instruction, observes the gated enables
  modport master (
    output en, Cond, ALUFlag, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, SkipCount
  );

  // Condition unit side
  modport slave (
    input  en, Cond, ALUFlag, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, SkipCount
  );

endinterface

// File: rtl/cond_unit_check.sv
// rtl/cond_unit_check.sv - combinational condition field evaluation
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field against the architectural flags; NV never passes
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - flag register, write-enable gating and squash counter
module cond_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        reset_n,
  cond_unit_if.slave bus
);

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] skip_q;
  logic             cond_ex;

  // Conditions always see the registered flags, so a flag-setting instruction
  // only influences the instruction after it
  cond_check u_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Architectural flags: each half written only by a passing, advancing instruction
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (bus.en && cond_ex) begin
      if (bus.FlagW[FLAGW_NZ]) begin
        flags_q[FLAG_N] <= bus.ALUFlag[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlag[FLAG_Z];
      end
      if (bus.FlagW[FLAGW_CV]) begin
        flags_q[FLAG_C] <= bus.ALUFlag[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlag[FLAG_V];
      end
    end
  end

  // Saturating count of squashed instructions, sticks at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skip_q <= '0;
    end else if (bus.en && !cond_ex && (skip_q != {CNT_W{1'b1}})) begin
      skip_q <= skip_q + 1'b1;
    end
  end

  // Side-effect enables only for advancing instructions whose condition passed
  always_comb begin
    bus.CondEx    = cond_ex;
    bus.PCSrc     = bus.PCS  & cond_ex & bus.en;
    bus.RegWrite  = bus.RegW & cond_ex & bus.en & ~bus.NoWrite;
    bus.MemWrite  = bus.MemW & cond_ex & bus.en;
    bus.Flags     = flags_q;
    bus.SkipCount = skip_q;
  end

endmodule
